// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg
//   Shared definitions for the 4-way round-robin arbiter: requester count,
//   index width, FSM state encoding and the rotating priority search.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // First set request bit found when scanning from ptr upward, wrapping
  // modulo NUM_REQ. Only meaningful when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// decoder_2x4_beh
//   2-to-4 one-hot decoder with enable. Output is all zero when disabled.
//   Ports:
//     i_a  [1:0]  select index
//     i_en        enable
//     o_y  [3:0]  one-hot output (bit i_a set when i_en=1)
module decoder_2x4_beh (
  input  logic [1:0] i_a,
  input  logic       i_en,
  output logic [3:0] o_y
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign o_y[gi] = i_en && (i_a == 2'(gi));
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
//   Round-robin arbiter sharing one resource among 4 requesters. A winner
//   holds the grant until it signals done, drops its request, or reaches the
//   hold limit; a mandatory one-cycle gap follows every grant, then priority
//   rotates to the requester after the previous owner.
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     i_req  [3:0] request vector, bit i = requester i
//     i_done       owner releases the resource (looked at only in GRANT)
//     o_gnt  [3:0] one-hot grant, zero when no grant is active
//     o_gnt_idx    index of current owner, 0 when idle
//     o_gnt_valid  a grant is active
//     o_timeout    1-cycle pulse in the gap after a forced revocation
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_done,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_valid,
  output logic               o_timeout
);

  // A zero-width counter is illegal, so the disabled-timeout build keeps 1 bit.
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t             r_state,     w_state_next;
  logic [IDX_W-1:0]   r_ptr,       w_ptr_next;
  logic [HOLD_W-1:0]  r_hold_cnt,  w_hold_cnt_next;
  logic [IDX_W-1:0]   r_gnt_idx,   w_gnt_idx_next;
  logic               r_gnt_valid, w_gnt_valid_next;
  logic               r_timeout,   w_timeout_next;

  logic               w_at_limit;
  logic               w_cnt_sat;
  logic               w_rel_done;
  logic               w_rel_drop;
  logic               w_rel_hold;

  if (MAX_HOLD != 0) begin : g_limit
    assign w_at_limit = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign w_cnt_sat  = w_at_limit;
  end else begin : g_no_limit
    assign w_at_limit = 1'b0;
    assign w_cnt_sat  = &r_hold_cnt;
  end

  assign w_rel_done = i_done;
  assign w_rel_drop = ~i_req[r_gnt_idx];
  assign w_rel_hold = w_at_limit;

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_hold_cnt_next  = r_hold_cnt;
    w_gnt_idx_next   = r_gnt_idx;
    w_gnt_valid_next = r_gnt_valid;
    w_timeout_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_next     = ST_GRANT;
          w_gnt_idx_next   = rr_pick(i_req, r_ptr);
          w_gnt_valid_next = 1'b1;
          w_hold_cnt_next  = '0;
        end
      end

      ST_GRANT: begin
        if (w_rel_done || w_rel_drop || w_rel_hold) begin
          w_state_next     = ST_GAP;
          w_gnt_valid_next = 1'b0;
          w_gnt_idx_next   = '0;
          w_ptr_next       = r_gnt_idx + 1'b1;
          w_hold_cnt_next  = '0;
          // Hold limit is the weakest cause: any normal release masks it.
          w_timeout_next   = w_rel_hold && !w_rel_done && !w_rel_drop;
        end else if (!w_cnt_sat) begin
          w_hold_cnt_next  = r_hold_cnt + 1'b1;
        end
      end

      ST_GAP: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_gnt_valid_next = 1'b0;
        w_gnt_idx_next   = '0;
        w_hold_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_timeout   <= w_timeout_next;
    end
  end

  // Decoding from the registered index+enable keeps o_gnt one-hot or zero.
  decoder_2x4_beh u_dec (
    .i_a  (r_gnt_idx),
    .i_en (r_gnt_valid),
    .o_y  (o_gnt)
  );

  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule
